// File: rtl/vending_core_param_pkg.sv
// Shared definitions for the parametrised vending core: FSM state encoding
// and default parameter values.
package vending_core_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_RETURN   = 2'd3
    } state_t;

    localparam int DEF_NUM_ITEMS   = 4;
    localparam int DEF_NUM_COINS   = 3;
    localparam int DEF_VALUE_BITS  = 16;
    localparam int DEF_TOTAL_BITS  = 31;
    localparam int DEF_WAIT_CYCLES = 100;

endpackage

// File: rtl/vending_core_param_change_select.sv
// Greedy change selector: picks the largest coin not exceeding the balance,
// or flags completion when even the smallest coin no longer fits.
module vending_change_select
    import vending_core_param_pkg::*;
#(
    parameter int NUM_COINS  = DEF_NUM_COINS,
    parameter int VALUE_BITS = DEF_VALUE_BITS,
    parameter int TOTAL_BITS = DEF_TOTAL_BITS
) (
    input  logic [TOTAL_BITS-1:0]           balance,
    input  logic [NUM_COINS*VALUE_BITS-1:0] coin_value,
    output logic [NUM_COINS-1:0]            coin_onehot,
    output logic [TOTAL_BITS-1:0]           coin_amt,
    output logic                            done
);

    localparam int CMP_W = (TOTAL_BITS > VALUE_BITS ? TOTAL_BITS : VALUE_BITS) + 1;

    logic [CMP_W-1:0] bal_ext;
    logic [CMP_W-1:0] val_ext;

    always_comb begin
        bal_ext     = CMP_W'(balance);
        val_ext     = '0;
        coin_onehot = '0;
        coin_amt    = '0;
        // Ascending scan: the last coin that fits is the highest one.
        for (int k = 0; k < NUM_COINS; k++) begin
            val_ext = CMP_W'(coin_value[k*VALUE_BITS +: VALUE_BITS]);
            if (val_ext <= bal_ext) begin
                coin_onehot    = '0;
                coin_onehot[k] = 1'b1;
                coin_amt       = TOTAL_BITS'(val_ext);
            end
        end
        done = bal_ext < CMP_W'(coin_value[0 +: VALUE_BITS]);
    end

endmodule

// File: rtl/vending_core_param.sv
// Parametrised vending-machine core: balance register, IDLE/ACTIVE/DISPENSE/
// RETURN FSM with inactivity timer, per-item availability and greedy change.
module vending_core_param
    import vending_core_param_pkg::*;
#(
    parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int NUM_COINS   = DEF_NUM_COINS,
    parameter int VALUE_BITS  = DEF_VALUE_BITS,
    parameter int TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_COINS-1:0]            i_input_coin,
    input  logic [NUM_ITEMS-1:0]            i_select_item,
    input  logic                            i_trigger_return,
    input  logic [NUM_ITEMS*VALUE_BITS-1:0] item_price,
    input  logic [NUM_COINS*VALUE_BITS-1:0] coin_value,
    output logic [NUM_ITEMS-1:0]            o_available_item,
    output logic [NUM_ITEMS-1:0]            o_output_item,
    output logic [NUM_COINS-1:0]            o_return_coin,
    output logic [TOTAL_BITS-1:0]           o_current_total,
    output logic                            o_coin_reject,
    output logic                            o_busy
);

    // Wide enough for balance plus every coin at once, and for any price.
    localparam int ACC_W   = (TOTAL_BITS > VALUE_BITS ? TOTAL_BITS : VALUE_BITS) + NUM_COINS + 1;
    localparam int TIMER_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [ACC_W-1:0]   MAX_TOTAL = {{(ACC_W-TOTAL_BITS){1'b0}}, {TOTAL_BITS{1'b1}}};
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(WAIT_CYCLES);

    state_t                state;
    logic [TOTAL_BITS-1:0] balance;
    logic [TIMER_W-1:0]    timer;

    logic [ACC_W-1:0]      add;
    logic [ACC_W-1:0]      sum_acc;
    logic                  accepting;
    logic                  coin_ok;
    logic                  coin_rej;
    logic [TOTAL_BITS-1:0] credited;
    logic [NUM_ITEMS-1:0]  avail;
    logic [NUM_ITEMS-1:0]  hit;
    logic [NUM_ITEMS-1:0]  sel_onehot;
    logic [ACC_W-1:0]      sel_price;
    logic [TOTAL_BITS-1:0] after_sale;

    logic [NUM_COINS-1:0]  chg_onehot;
    logic [TOTAL_BITS-1:0] chg_amt;
    logic                  chg_done;

    always_comb begin
        add = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (i_input_coin[k]) begin
                add = add + ACC_W'(coin_value[k*VALUE_BITS +: VALUE_BITS]);
            end
        end
        sum_acc   = ACC_W'(balance) + add;
        accepting = (state == ST_IDLE) || (state == ST_ACTIVE);
        coin_ok   = (|i_input_coin) && accepting && (sum_acc <= MAX_TOTAL);
        coin_rej  = (|i_input_coin) && !coin_ok;
        credited  = coin_ok ? TOTAL_BITS'(sum_acc) : balance;
    end

    always_comb begin
        avail = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            avail[i] = (state == ST_ACTIVE) &&
                       (ACC_W'(balance) >= ACC_W'(item_price[i*VALUE_BITS +: VALUE_BITS]));
        end
        hit        = i_select_item & avail;
        sel_onehot = '0;
        sel_price  = '0;
        // Descending scan so the lowest requested index is the one kept.
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_price     = ACC_W'(item_price[i*VALUE_BITS +: VALUE_BITS]);
            end
        end
        after_sale = TOTAL_BITS'(ACC_W'(credited) - sel_price);
    end

    vending_change_select #(
        .NUM_COINS  (NUM_COINS),
        .VALUE_BITS (VALUE_BITS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_change (
        .balance     (balance),
        .coin_value  (coin_value),
        .coin_onehot (chg_onehot),
        .coin_amt    (chg_amt),
        .done        (chg_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            balance       <= '0;
            timer         <= '0;
            o_output_item <= '0;
            o_return_coin <= '0;
            o_coin_reject <= 1'b0;
        end else begin
            o_output_item <= '0;
            o_return_coin <= '0;
            o_coin_reject <= coin_rej;
            case (state)
                ST_IDLE: begin
                    if (coin_ok) begin
                        balance <= credited;
                        timer   <= TIMER_RELOAD;
                        state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (|hit) begin
                        balance       <= after_sale;
                        timer         <= TIMER_RELOAD;
                        o_output_item <= sel_onehot;
                        state         <= ST_DISPENSE;
                    end else begin
                        if (coin_ok) begin
                            balance <= credited;
                            timer   <= TIMER_RELOAD;
                        end else if (timer != '0) begin
                            timer <= timer - TIMER_W'(1);
                        end
                        // A coin accepted on the expiry cycle restarts the wait.
                        if (i_trigger_return || (timer == '0 && !coin_ok)) begin
                            state <= ST_RETURN;
                        end
                    end
                end
                ST_DISPENSE: begin
                    state <= ST_ACTIVE;
                end
                ST_RETURN: begin
                    if (chg_done) begin
                        balance <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        o_return_coin <= chg_onehot;
                        balance       <= balance - chg_amt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_available_item = avail;
    assign o_current_total  = balance;
    assign o_busy           = (state == ST_DISPENSE) || (state == ST_RETURN);

endmodule

// File: tb/tb_vending_core_param.sv
// Scoreboard bench for vending_core_param: default instance plus a 10-bit
// balance instance for the overflow and mid-return reset scenarios.
module tb_vending_core_param;

    localparam int W = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] prices = {16'd2000, 16'd1000, 16'd500, 16'd400};
    logic [47:0] coins  = {16'd1000, 16'd500, 16'd100};

    logic        rst1, trig1, rej1, busy1;
    logic [2:0]  coin1, ret1;
    logic [3:0]  sel1, avail1, item1;
    logic [30:0] total1;

    logic        rst2, trig2, rej2, busy2;
    logic [2:0]  coin2, ret2;
    logic [3:0]  sel2, avail2, item2;
    logic [9:0]  total2;

    vending_core_param dut1 (
        .clk(clk), .reset_n(rst1), .i_input_coin(coin1), .i_select_item(sel1),
        .i_trigger_return(trig1), .item_price(prices), .coin_value(coins),
        .o_available_item(avail1), .o_output_item(item1), .o_return_coin(ret1),
        .o_current_total(total1), .o_coin_reject(rej1), .o_busy(busy1)
    );

    vending_core_param #(.TOTAL_BITS(10)) dut2 (
        .clk(clk), .reset_n(rst2), .i_input_coin(coin2), .i_select_item(sel2),
        .i_trigger_return(trig2), .item_price(prices), .coin_value(coins),
        .o_available_item(avail2), .o_output_item(item2), .o_return_coin(ret2),
        .o_current_total(total2), .o_coin_reject(rej2), .o_busy(busy2)
    );

    int n_cmp = 0;
    int n_fail = 0;
    // Event word: {reject, return_coin[2:0], output_item[3:0]}
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor_one(input string name, input logic [7:0] w, inout logic [7:0] q[$]);
        logic [7:0] e;
        if (w != 8'd0) begin
            if (q.size() == 0) begin
                check({name, "_unexpected"}, 32'(w), 32'd0);
            end else begin
                e = q.pop_front();
                check(name, 32'(w), 32'(e));
            end
        end
    endtask

    task automatic wait_idle1(input string name);
        int n = 0;
        while (busy1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_bound"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        int cnt;
        rst1 = 1'b0; coin1 = '0; sel1 = '0; trig1 = 1'b0;
        rst2 = 1'b0; coin2 = '0; sel2 = '0; trig2 = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_one("evt1", {rej1, ret1, item1}, q1);
                monitor_one("evt2", {rej2, ret2, item2}, q2);
            end
        join_none
        repeat (2) @(negedge clk);
        check("rst_total", 32'(total1), 32'd0);
        check("rst_avail", 32'(avail1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_outs", 32'({rej1, ret1, item1}), 32'd0);
        rst1 = 1'b1; rst2 = 1'b1;

        // Two 500 coins
        coin1 = 3'b010;
        @(negedge clk); check("coin_500", 32'(total1), 32'd500);
        @(negedge clk); check("coin_1000", 32'(total1), 32'd1000);
        coin1 = '0;
        check("avail_1000", 32'(avail1), 32'b0111);

        // Buy item 2 (1000)
        sel1 = 4'b0100; q1.push_back(8'b0000_0100);
        @(negedge clk);
        check("sale2_total", 32'(total1), 32'd0);
        check("sale2_busy", 32'(busy1), 32'd1);
        sel1 = '0;
        @(negedge clk);
        check("sale2_avail", 32'(avail1), 32'd0);
        check("sale2_unbusy", 32'(busy1), 32'd0);

        // 600, request items 0 and 1 -> lowest index wins; coin during DISPENSE rejected
        coin1 = 3'b010; @(negedge clk);
        coin1 = 3'b001; @(negedge clk);
        coin1 = '0;
        check("total_600", 32'(total1), 32'd600);
        check("avail_600", 32'(avail1), 32'b0011);
        sel1 = 4'b0011; q1.push_back(8'b0000_0001);
        @(negedge clk);
        check("sale0_total", 32'(total1), 32'd200);
        sel1 = '0; coin1 = 3'b001; q1.push_back(8'b1000_0000);
        @(negedge clk);
        coin1 = '0;
        check("disp_reject_total", 32'(total1), 32'd200);

        // Return 200 -> two 100 coins
        trig1 = 1'b1; q1.push_back(8'b0001_0000); q1.push_back(8'b0001_0000);
        @(negedge clk); trig1 = 1'b0;
        check("ret200_busy", 32'(busy1), 32'd1);
        wait_idle1("ret200");
        check("ret200_total", 32'(total1), 32'd0);

        // Three coins in one cycle -> 1600, then greedy return 1000/500/100
        coin1 = 3'b111; @(negedge clk); coin1 = '0;
        check("total_1600", 32'(total1), 32'd1600);
        trig1 = 1'b1;
        q1.push_back(8'b0100_0000); q1.push_back(8'b0010_0000); q1.push_back(8'b0001_0000);
        @(negedge clk); trig1 = 1'b0;
        check("ret1600_busy", 32'(busy1), 32'd1);
        wait_idle1("ret1600");
        check("ret1600_total", 32'(total1), 32'd0);
        check("ret1600_avail", 32'(avail1), 32'd0);

        // Inactivity timeout with 100 credited
        coin1 = 3'b001; @(negedge clk); coin1 = '0;
        check("to_total", 32'(total1), 32'd100);
        q1.push_back(8'b0001_0000);
        cnt = 0;
        while (!busy1 && cnt < 3 * W) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles_ok", 32'(cnt >= W && cnt <= W + 1), 32'd1);
        wait_idle1("to");
        check("to_final_total", 32'(total1), 32'd0);

        // 10-bit balance: overflow reject, then async reset mid-RETURN
        coin2 = 3'b011; @(negedge clk);
        coin2 = 3'b100; q2.push_back(8'b1000_0000); @(negedge clk);
        coin2 = '0;
        check("ovf_total", 32'(total2), 32'd600);
        trig2 = 1'b1; @(negedge clk); trig2 = 1'b0;
        check("ovf_ret_busy", 32'(busy2), 32'd1);
        q2.push_back(8'b0010_0000);
        @(negedge clk);
        check("mid_ret_total", 32'(total2), 32'd100);
        #2 rst2 = 1'b0;
        #1;
        check("async_total", 32'(total2), 32'd0);
        check("async_outs", 32'({rej2, ret2, item2}), 32'd0);
        check("async_busy", 32'(busy2), 32'd0);
        @(negedge clk); rst2 = 1'b1;
        repeat (2) @(negedge clk);

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
